mem_read_fsm: RTL and testbench
===============================

# mem_read_fsm

Reads a completed frame of ToF readings back out of the capture BRAM (port B) once the capture side reports all data written, and streams each word as two bytes over a valid/ready byte interface toward the UART transmitter. It is the readout counterpart of the capture write FSM and shares the same BRAM. Exactly one frame of DEPTH words is read per start, in address order.

## Interface
- DEPTH, 512, number of words read per frame
- ADDR_W, 9, BRAM address width; DEPTH ≤ 2**ADDR_W
- DATA_W, 16, BRAM word width; fixed at 16 (two bytes per word)
- RD_LAT, 2, BRAM port-B read latency in cycles; legal range 1..3
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high
- start  input  1  frame-readout request (tie to capture-side all_data_written); level or pulse
- enb  output  1  BRAM port-B read enable
- addrb  output  ADDR_W  BRAM port-B address
- doutb  input  DATA_W  BRAM port-B read data, valid RD_LAT cycles after enb
- tx_data  output  8  byte to transmitter
- tx_valid  output  1  tx_data valid; held until accepted
- tx_ready  input  1  transmitter accepts byte when high with tx_valid
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after final byte accepted

## Operation
- States: IDLE, RD, WAIT, SEND_HI, SEND_LO, DONE.
- IDLE: addr register = 0. start=1 → RD. start is ignored in all other states.
- RD (1 cycle): enb=1, addrb=addr. → WAIT, latency counter loaded with RD_LAT-1.
- WAIT (RD_LAT cycles): enb=0. At the end of the last WAIT cycle, doutb is captured into word register. → SEND_HI.
- SEND_HI: tx_valid=1, tx_data=word[15:8]. tx_ready=1 → SEND_LO. Otherwise stay; tx_data stable.
- SEND_LO: tx_valid=1, tx_data=word[7:0]. tx_ready=1 → if addr==DEPTH-1 then DONE, else addr+1 and RD.
- DONE (1 cycle): done=1. → IDLE. addr cleared to 0.
- If start is still high in the IDLE cycle after DONE, a new frame begins. A level start therefore repeats frames; the capture side must drop all_data_written between frames.
- addrb is driven from the addr register at all times. Its value is meaningful only while enb=1.
- The word register is written only in the final WAIT cycle. It is never modified during SEND_HI or SEND_LO.

## Timing
- Reset values: enb=0, addrb=0, tx_data=0, tx_valid=0, busy=0, done=0, state=IDLE, latency counter=0, word register=0.
- Reset asserted in any state forces all of the above on the next edge. A partial frame is abandoned, no done pulse is issued, and any pending tx_valid drops.
- start sampled high in IDLE at edge k: enb=1 in cycle k+1, first tx_valid in cycle k+2+RD_LAT.
- Minimum per-word period with tx_ready tied high: 3+RD_LAT cycles (5 at default). Full frame is DEPTH·(3+RD_LAT) cycles, followed by 1 DONE cycle.
- tx_valid never deasserts without a handshake, except on reset. tx_data is constant while tx_valid=1 and tx_ready=0.
- enb is high exactly once per word. There is never more than one outstanding read.
- done rises in the cycle after the final SEND_LO handshake and lasts 1 cycle. busy is low in that same following cycle's successor (IDLE).
- The addr increment is ADDR_W-bit. It never wraps within a frame, because the terminal test is addr==DEPTH-1.

## Structure
- Shared package mem_rd_pkg holds the state enum (6 states, 3-bit encoding) and localparams BYTES_PER_WORD=2 and the default DEPTH/ADDR_W/RD_LAT. Both capture and readout FSMs import the depth constant so the frame sizes cannot diverge.
- Single module, no sub-module. The latency counter, address counter and byte mux are inline.

## Test plan
- Reset then start pulse, BRAM model preloaded with addr→{addr[7:0],~addr[7:0]}, RD_LAT=2, tx_ready=1 → 1024 bytes in address order, 0x00,0xFF,0x01,0xFE,…; byte pairs every 5 cycles; done pulses once; busy low afterward.
- Random tx_ready backpressure (≈30% high) → identical byte sequence; tx_data stable whenever tx_valid=1 and tx_ready=0; enb count = 512.
- RD_LAT=1 and RD_LAT=3 builds → correct data per word; per-word period 4 and 6 cycles respectively.
- start held high through the frame and for 2 cycles after DONE → no restart mid-frame; second frame starts in the IDLE cycle following DONE.
- Reset asserted during SEND_LO of word 100 → next cycle tx_valid=0, busy=0, no done; a later start reads from address 0.
- DEPTH=4 build → 8 bytes, addrb sequence 0,1,2,3, done after the 8th handshake.

Source files
------------

// File: rtl/mem_rd_pkg.sv
// Shared frame-readout definitions: state encoding and frame geometry defaults.
// Capture and readout FSMs both import DEPTH_DEF so frame sizes cannot diverge.
package mem_rd_pkg;

    localparam int unsigned BYTES_PER_WORD = 2;
    localparam int unsigned DEPTH_DEF      = 512;
    localparam int unsigned ADDR_W_DEF     = 9;
    localparam int unsigned RD_LAT_DEF     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_SEND_HI,
        ST_SEND_LO,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_read_fsm.sv
// Reads one frame of DEPTH words from capture BRAM port B and streams each word
// high byte first over a valid/ready byte interface toward the UART transmitter.
module mem_read_fsm
    import mem_rd_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LAT_W = 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   addr;
    logic [LAT_W-1:0]    lat_cnt;
    logic [DATA_W-1:0]   word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start) state_nx = ST_RD;
            ST_RD:      state_nx = ST_WAIT;
            ST_WAIT:    if (lat_cnt == '0) state_nx = ST_SEND_HI;
            ST_SEND_HI: if (tx_ready) state_nx = ST_SEND_LO;
            ST_SEND_LO: if (tx_ready) state_nx = (addr == LAST_ADDR) ? ST_DONE : ST_RD;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Word register loads only on the last WAIT cycle, so bytes stay stable under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr    <= '0;
            lat_cnt <= '0;
            word    <= '0;
        end else begin
            case (state)
                ST_RD: lat_cnt <= LAT_W'(RD_LAT - 1);
                ST_WAIT: begin
                    if (lat_cnt == '0) begin
                        word <= doutb;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                ST_SEND_LO: begin
                    if (tx_ready && (addr != LAST_ADDR)) begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                ST_DONE: addr <= '0;
                default: ;
            endcase
        end
    end

    assign addrb = addr;

    always_comb begin
        enb      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            ST_IDLE:    busy = 1'b0;
            ST_RD:      enb = 1'b1;
            ST_SEND_HI: begin
                tx_valid = 1'b1;
                tx_data  = word[15:8];
            end
            ST_SEND_LO: begin
                tx_valid = 1'b1;
                tx_data  = word[7:0];
            end
            ST_DONE:    done = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: tb/tb_mem_read_fsm.sv
// Scoreboard bench for mem_read_fsm: BRAM model with RD_LAT pipeline, byte queue,
// backpressure, level start, and mid-frame reset.
module tb_mem_read_fsm;

    localparam int unsigned DEPTH  = 512;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned RD_LAT = 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic              enb;
    logic [ADDR_W-1:0] addrb;
    logic [15:0]       doutb;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    mem_read_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (16),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .enb      (enb),
        .addrb    (addrb),
        .doutb    (doutb),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    int         exp_addr = 0;
    int         enb_cnt = 0;
    int         done_cnt = 0;
    int         hs_cnt = 0;
    int         cyc = 0;
    int         last_hi = 0;
    bit         have_hi = 0;
    bit         per_chk = 0;
    bit         rand_mode = 0;
    logic       tx_ready_lvl = 1'b0;
    logic       rst_edge = 1'b1;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = '0;
    int         frames_done = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {b, ~b};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM port B: data for the enabled address appears RD_LAT cycles later, then moves on.
    logic [15:0] pipe [RD_LAT];
    always_ff @(posedge clk) begin
        pipe[0] <= enb ? mem_word(int'(addrb)) : 16'hDEAD;
        for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign doutb = pipe[RD_LAT-1];

    always_ff @(posedge clk) rst_edge <= reset;

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_mode ? ($urandom_range(0, 99) < 30) : tx_ready_lvl;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_edge) begin
                if (enb) begin
                    check_eq("addrb", 32'(addrb), 32'(exp_addr));
                    exp_addr++;
                    enb_cnt++;
                end
                if (done) begin
                    done_cnt++;
                    exp_addr = 0;
                end
                if (prev_valid && !prev_ready) begin
                    check_eq("hold_valid", 32'(tx_valid), 32'd1);
                    check_eq("hold_data", 32'(tx_data), 32'(prev_data));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) check_eq("byte_avail", 32'(exp_q.size()), 32'd1);
                    else check_eq("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
                    if ((hs_cnt % 2) == 0 && per_chk) begin
                        if (have_hi) check_eq("period", 32'(cyc - last_hi), 32'(3 + RD_LAT));
                        last_hi = cyc;
                        have_hi = 1;
                    end
                    hs_cnt++;
                end
            end else begin
                exp_addr = 0;
            end
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_data  = tx_data;
            cyc++;
        end
    end

    task automatic push_frame;
        logic [15:0] w;
        for (int a = 0; a < int'(DEPTH); a++) begin
            w = mem_word(a);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
    endtask

    task automatic pulse_start;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge of the cycle after DONE (IDLE).
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        check_eq("done_seen", 32'(done), 32'd1);
        frames_done++;
        @(negedge clk);
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("enb_idle", 32'(enb), 32'd0);
        check_eq("done_cnt", 32'(done_cnt), 32'(frames_done));
        check_eq("enb_cnt", 32'(enb_cnt), 32'(DEPTH));
        check_eq("q_empty", 32'(exp_q.size()), 32'd0);
        enb_cnt = 0;
        hs_cnt  = 0;
        have_hi = 0;
    endtask

    initial begin
        int n;
        int first_enb;
        int done_before;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_enb", 32'(enb), 32'd0);
        check_eq("rst_addrb", 32'(addrb), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Frame 1: ready tied high, latency and per-word period checked.
        tx_ready_lvl = 1'b1;
        per_chk = 1;
        push_frame();
        pulse_start();
        n = 0;
        first_enb = 0;
        do begin
            @(negedge clk);
            n++;
            if (enb && first_enb == 0) first_enb = n;
        end while (!tx_valid && n < 20);
        check_eq("enb_lat", 32'(first_enb), 32'd1);
        check_eq("valid_lat", 32'(n), 32'(2 + RD_LAT));
        wait_done(int'(DEPTH * (3 + RD_LAT)) + 20);

        // Frame 2: random backpressure.
        per_chk = 0;
        rand_mode = 1;
        push_frame();
        pulse_start();
        wait_done(int'(DEPTH) * 60);
        rand_mode = 0;

        // Frames 3/4: level start held through the frame and two cycles past DONE.
        per_chk = 1;
        push_frame();
        @(posedge clk);
        #1 start = 1'b1;
        wait_done(int'(DEPTH * (3 + RD_LAT)) + 20);
        push_frame();
        @(negedge clk);
        check_eq("restart_enb", 32'(enb), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(int'(DEPTH * (3 + RD_LAT)) + 20);

        // Reset in SEND_LO of word 100.
        push_frame();
        pulse_start();
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (hs_cnt < 201 && n < 2000);
        check_eq("reach_w100", 32'(hs_cnt), 32'd201);
        check_eq("w100_lo_valid", 32'(tx_valid), 32'd1);
        tx_ready_lvl = 1'b0;
        tx_ready = 1'b0;
        reset = 1'b1;
        done_before = done_cnt;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_rst_valid", 32'(tx_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_addrb", 32'(addrb), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        enb_cnt = 0;
        hs_cnt = 0;
        have_hi = 0;
        repeat (5) @(negedge clk);
        check_eq("no_done_after_rst", 32'(done_cnt), 32'(done_before));
        check_eq("idle_after_rst", 32'(busy), 32'd0);

        // Frame 5: restarts from address 0.
        tx_ready_lvl = 1'b1;
        push_frame();
        pulse_start();
        wait_done(int'(DEPTH * (3 + RD_LAT)) + 20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired: checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
